costas_dds_loader: RTL

Serial AD9850 loader that consumes the Costas trigger and symbol clock produced by the beacon timing top level. It shifts one 40-bit DDS word per symbol and pulses FQ_UD to apply it. It raises a transmit request back toward the timing block for the duration of a sequence, so the timing block's own fq_ud gating is honoured. It sits between the beacon timing logic and the AD9850 W_CLK/DATA/FQ_UD pins, and replaces the MCU bit-banging path for Costas transmissions.

---
 rtl/costas_pkg.sv | 55 +++++
 rtl/costas_dds_loader_if.sv | 9 +
 rtl/ad9850_serializer.sv | 124 ++++++++++++
 rtl/costas_dds_loader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/costas_pkg.sv
// Shared constants, state encodings and AD9850 word helpers for the Costas DDS loader.
// The optional power-down state is present only when DDS_POWERDOWN_EN is defined.
package costas_pkg;

    localparam int N_SYM    = 6;
    localparam int WORD_LEN = 40;
    localparam int FTW_LEN  = 32;
    localparam int PD_BIT   = 34;
    localparam logic [1:0] CTRL_BITS = 2'b00;

    // Welch order-6 Costas array, index 0 is transmitted first
    localparam logic [2:0] COSTAS_SEQ [N_SYM] = '{3'd2, 3'd1, 3'd5, 3'd3, 3'd4, 3'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYM,
        S_SHIFT,
`ifdef DDS_POWERDOWN_EN
        S_FQUD,
        S_PD
`else
        S_FQUD
`endif
    } state_t;

    typedef enum logic [2:0] {
        SER_IDLE,
        SER_SETUP,
        SER_HIGH,
        SER_LOW,
        SER_FQ
    } ser_phase_t;

    // Tuning word for symbol idx; the sum wraps modulo 2^32
    function automatic logic [FTW_LEN-1:0] tone_ftw(input logic [FTW_LEN-1:0] base,
                                                    input logic [FTW_LEN-1:0] step,
                                                    input logic [2:0] idx);
        logic [FTW_LEN-1:0] tone;
        tone = (int'(idx) < N_SYM) ? FTW_LEN'(COSTAS_SEQ[idx]) : '0;
        return base + tone * step;
    endfunction

    function automatic logic [WORD_LEN-1:0] dds_word(input logic [4:0] phase,
                                                     input logic pd,
                                                     input logic [FTW_LEN-1:0] ftw);
        logic [WORD_LEN-1:0] w;
        w = '0;
        w[FTW_LEN-1:0]         = ftw;
        w[PD_BIT-1 -: 2]       = CTRL_BITS;
        w[PD_BIT]              = pd;
        w[WORD_LEN-1 -: 5]     = phase;
        return w;
    endfunction

endpackage

// File: rtl/costas_dds_loader_if.sv
// AD9850 serial load pins: W_CLK, DATA (D7) and FQ_UD.
interface costas_dds_loader_if;
    logic dds_wclk;
    logic dds_data;
    logic dds_fq_ud;

    modport master (output dds_wclk, output dds_data, output dds_fq_ud);
    modport slave  (input  dds_wclk, input  dds_data, input  dds_fq_ud);
endinterface

// File: rtl/ad9850_serializer.sv
// Shifts one 40-bit AD9850 word LSB first on W_CLK, then pulses FQ_UD.
// Each phase (W_CLK high, W_CLK low, FQ_UD high) lasts WCLK_DIV cycles.
module ad9850_serializer
    import costas_pkg::*;
#(
    parameter int WCLK_DIV = 4
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [WORD_LEN-1:0] word,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                fq_active,
    costas_dds_loader_if.master dds
);

    localparam int CNT_W = (WCLK_DIV > 1) ? $clog2(WCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WCLK_DIV - 1);

    ser_phase_t          phase_reg, phase_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [5:0]          bit_reg, bit_next;
    logic [WORD_LEN-1:0] shift_reg, shift_next;
    logic                wclk_reg, wclk_next;
    logic                data_reg, data_next;
    logic                fq_reg, fq_next;
    logic                cnt_last;

    assign cnt_last = (cnt_reg == CNT_LAST);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            phase_reg <= SER_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            wclk_reg  <= 1'b0;
            data_reg  <= 1'b0;
            fq_reg    <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            wclk_reg  <= wclk_next;
            data_reg  <= data_next;
            fq_reg    <= fq_next;
        end
    end

    always_comb begin
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        wclk_next  = wclk_reg;
        data_next  = data_reg;
        fq_next    = fq_reg;
        case (phase_reg)
            SER_IDLE: begin
                if (start) begin
                    shift_next = word;
                    data_next  = word[0];
                    bit_next   = '0;
                    cnt_next   = '0;
                    phase_next = SER_SETUP;
                end
            end
            // One cycle of data setup before the first W_CLK rise
            SER_SETUP: begin
                wclk_next  = 1'b1;
                cnt_next   = '0;
                phase_next = SER_HIGH;
            end
            SER_HIGH: begin
                if (cnt_last) begin
                    wclk_next  = 1'b0;
                    cnt_next   = '0;
                    shift_next = shift_reg >> 1;
                    data_next  = shift_reg[1];
                    phase_next = SER_LOW;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SER_LOW: begin
                if (cnt_last) begin
                    cnt_next = '0;
                    if (bit_reg == 6'(WORD_LEN - 1)) begin
                        fq_next    = 1'b1;
                        phase_next = SER_FQ;
                    end else begin
                        bit_next   = bit_reg + 6'd1;
                        wclk_next  = 1'b1;
                        phase_next = SER_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SER_FQ: begin
                if (cnt_last) begin
                    fq_next    = 1'b0;
                    cnt_next   = '0;
                    phase_next = SER_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: phase_next = SER_IDLE;
        endcase
    end

    always_comb begin
        busy          = (phase_reg != SER_IDLE);
        done          = (phase_reg == SER_FQ) && cnt_last;
        fq_active     = fq_reg;
        dds.dds_wclk  = wclk_reg;
        dds.dds_data  = data_reg;
        dds.dds_fq_ud = fq_reg;
    end

endmodule

// File: rtl/costas_dds_loader.sv
// Sequences the six Costas symbols into an AD9850, one word per symbol clock edge.
// Define DDS_POWERDOWN_EN to append a power-down word after the last symbol.
module costas_dds_loader
    import costas_pkg::*;
#(
    parameter int         WCLK_DIV   = 4,
    parameter logic [4:0] PHASE_WORD = 5'd0
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        costas_trig,
    input  logic        costas_symclk,
    input  logic [31:0] base_ftw,
    input  logic [31:0] step_ftw,
    costas_dds_loader_if.master dds,
    output logic        costas_txrq,
    output logic [2:0]  sym_idx,
    output logic        overrun
);

    logic [1:0] async_in;
    logic [1:0] sync_lvl;
    logic [1:0] rise;

    assign async_in = {costas_symclk, costas_trig};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg, sync_reg, prev_reg;
            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end
            assign sync_lvl[gi] = sync_reg;
            assign rise[gi]     = sync_reg & ~prev_reg;
        end
    endgenerate

    logic trig_lvl, trig_rise, sym_rise;
    assign trig_lvl  = sync_lvl[0];
    assign trig_rise = rise[0];
    assign sym_rise  = rise[1];

    state_t              state_reg, state_next;
    logic [31:0]         base_reg, step_reg;
    logic [2:0]          sym_idx_reg;
    logic                txrq_reg, overrun_reg;
    logic                ser_start, ser_busy, ser_done, ser_fq;
    logic [WORD_LEN-1:0] ser_word;
    logic                sym_go, word_active, edge_busy, last_sym;

    assign last_sym    = (sym_idx_reg == 3'(N_SYM - 1));
    assign sym_go      = trig_lvl && sym_rise && !ser_busy;
    assign word_active = (state_reg == S_SHIFT) || (state_reg == S_FQUD);
`ifdef DDS_POWERDOWN_EN
    assign edge_busy   = word_active || (state_reg == S_PD);
`else
    assign edge_busy   = word_active;
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (trig_rise) state_next = S_WAIT_SYM;
            // A trig that dropped during the previous word aborts here
            S_WAIT_SYM: begin
                if (!trig_lvl)   state_next = S_IDLE;
                else if (sym_go) state_next = S_SHIFT;
            end
            S_SHIFT, S_FQUD: begin
                if (ser_done) begin
`ifdef DDS_POWERDOWN_EN
                    state_next = last_sym ? S_PD : S_WAIT_SYM;
`else
                    state_next = last_sym ? S_IDLE : S_WAIT_SYM;
`endif
                end else if (ser_fq) begin
                    state_next = S_FQUD;
                end
            end
`ifdef DDS_POWERDOWN_EN
            S_PD:       if (ser_done) state_next = S_IDLE;
`endif
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ser_start = 1'b0;
        ser_word  = dds_word(PHASE_WORD, 1'b0, tone_ftw(base_reg, step_reg, sym_idx_reg));
        case (state_reg)
            S_WAIT_SYM: ser_start = sym_go;
`ifdef DDS_POWERDOWN_EN
            // Serializer is idle only on the first PD cycle
            S_PD: begin
                ser_start = !ser_busy;
                ser_word  = dds_word(PHASE_WORD, 1'b1, '0);
            end
`endif
            default: ser_start = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            base_reg    <= '0;
            step_reg    <= '0;
            sym_idx_reg <= '0;
            txrq_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && trig_rise) begin
                base_reg    <= base_ftw;
                step_reg    <= step_ftw;
                sym_idx_reg <= '0;
                txrq_reg    <= 1'b1;
                overrun_reg <= 1'b0;
            end
            if (state_reg == S_WAIT_SYM && !trig_lvl)
                txrq_reg <= 1'b0;
            if (word_active && ser_done) begin
                if (last_sym) txrq_reg    <= 1'b0;
                else          sym_idx_reg <= sym_idx_reg + 3'd1;
            end
            if (edge_busy && sym_rise)
                overrun_reg <= 1'b1;
        end
    end

    ad9850_serializer #(.WCLK_DIV(WCLK_DIV)) u_ser (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .word      (ser_word),
        .start     (ser_start),
        .busy      (ser_busy),
        .done      (ser_done),
        .fq_active (ser_fq),
        .dds       (dds)
    );

    assign costas_txrq = txrq_reg;
    assign sym_idx     = sym_idx_reg;
    assign overrun     = overrun_reg;

endmodule
